// File: rtl/mac_seq_ctrl.sv
// Control sequencer for the small-matrix MAC: loads A/B, walks C[i][j] with K
// element reads each, accumulates products, writes C and triggers the read-out.
module mac_seq_ctrl #(
    parameter int param_M            = 4,
    parameter int param_K            = 4,
    parameter int param_N            = 4,
    parameter int DATA_WIDTH_INITIAL = 8,
    parameter int DATA_WIDTH_FINAL   = DATA_WIDTH_INITIAL * 2
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   start,
    input  logic                                   abort,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   a_b_we,
    output logic                                   a_b_re,
    output logic [$clog2(param_M*param_K)-1:0]     a_addr,
    output logic [$clog2(param_K*param_N)-1:0]     b_addr,
    input  logic [DATA_WIDTH_INITIAL-1:0]          a_data_out,
    input  logic [DATA_WIDTH_INITIAL-1:0]          b_data_out,
    output logic                                   c_we,
    output logic [$clog2(param_M*param_N)-1:0]     c_addr,
    output logic [DATA_WIDTH_FINAL-1:0]            c_data_in,
    output logic                                   c_re
);

    localparam int AW_A = $clog2(param_M * param_K);
    localparam int AW_B = $clog2(param_K * param_N);
    localparam int AW_C = $clog2(param_M * param_N);
    localparam int IW   = (param_M > 1) ? $clog2(param_M) : 1;
    localparam int JW   = (param_N > 1) ? $clog2(param_N) : 1;
    localparam int KW   = (param_K > 1) ? $clog2(param_K) : 1;
    localparam int PW   = DATA_WIDTH_INITIAL * 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_CREAD,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [IW-1:0]               i_q, i_d;
    logic [JW-1:0]               j_q, j_d;
    logic [KW-1:0]               k_q, k_d;
    logic                        valid_q, valid_d;
    logic [DATA_WIDTH_FINAL-1:0] acc_q, acc_d;
    logic [PW-1:0]               product;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            valid_q <= valid_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_READ;
            S_READ: begin
                if (k_q == KW'(param_K - 1)) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: begin
                // Last element holds its indices; they are cleared on IDLE entry.
                if (j_q == JW'(param_N - 1)) begin
                    if (i_q == IW'(param_M - 1)) begin
                        state_d = S_CREAD;
                    end else begin
                        i_d     = i_q + IW'(1);
                        j_d     = '0;
                        state_d = S_READ;
                    end
                end else begin
                    j_d     = j_q + JW'(1);
                    state_d = S_READ;
                end
            end
            S_CREAD: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
        if (state_d == S_IDLE) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end
    end

    // Memory read data arrives one cycle after a_b_re; valid tracks that delay.
    assign product = PW'(a_data_out) * PW'(b_data_out);

    always_comb begin
        valid_d = (state_q == S_READ) && !abort;
        acc_d   = acc_q;
        if (state_q == S_LOAD || state_q == S_WRITE) begin
            acc_d = '0;
        end else if (valid_q) begin
            acc_d = acc_q + DATA_WIDTH_FINAL'(product);
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign a_b_we = (state_q == S_LOAD);
    assign a_b_re = (state_q == S_READ);
    assign c_we   = (state_q == S_WRITE);
    assign c_re   = (state_q == S_CREAD);

    always_comb begin
        a_addr    = '0;
        b_addr    = '0;
        c_addr    = '0;
        c_data_in = '0;
        if (state_q == S_READ) begin
            a_addr = AW_A'(int'(i_q) * param_K + int'(k_q));
            b_addr = AW_B'(int'(k_q) * param_N + int'(j_q));
        end
        if (state_q == S_WRITE) begin
            c_addr    = AW_C'(int'(i_q) * param_N + int'(j_q));
            c_data_in = acc_q;
        end
    end

endmodule
